ctrl_unit_pipe: RTL and testbench

Registered ID-stage control decoder for the 5-stage MIPS pipeline, the parametrised successor of the single-mode control unit. Each cycle it decodes the IF/ID instruction into the ID/EX control bundle. A sequencer adds three things: a configurable flush depth after EX/MEM redirects, a selectable stall policy (bubble or hold), and interrupt entry/return sequencing with `rti`. All outputs are registered, so the bundle lands in ID/EX one cycle after the instruction is presented.

---
 rtl/ctrl_unit_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_ctrl_unit_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered ID-stage control decoder with
// redirect flush, stall policy and interrupt sequencing.
module ctrl_unit_pipe #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter bit          STALL_HOLD   = 1'b0,
  parameter bit          INTR_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_instr,
  input  logic        em_pcsrc,
  input  logic [1:0]  em_jump,
  input  logic        stall,
  input  logic        intr_req,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        mem_read,
  output logic        alu_src,
  output logic        reg_write,
  output logic        branch_bne,
  output logic        branch_bgtz,
  output logic        branch_beq,
  output logic [1:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  jump,
  output logic        rti_o,
  output logic        illegal_o,
  output logic        intr_ack,
  output logic        intr_active
);

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_write;
    logic       branch_bne;
    logic       branch_bgtz;
    logic       branch_beq;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] jump;
    logic       rti;
    logic       illegal;
  } ctrl_t;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_ISR   = 2'd2;

  localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused;

  assign op     = if_instr[31:26];
  assign fn     = if_instr[5:0];
  assign unused = ^if_instr[25:6];

  logic is_r;
  logic is_jr;
  logic is_alui;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_bne;
  logic is_bgtz;
  logic is_j;
  logic is_jal;
  logic is_rti;

  assign is_r    = (op == 6'h00);
  assign is_jr   = (fn == 6'h08);
  assign is_alui = (op[5:3] == 3'b001);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_bgtz = (op == 6'h07);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);
  assign is_rti  = (op == 6'h3F);

  ctrl_t dec;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_r: begin
        dec.alu_op    = 2'd2;
        dec.reg_dst   = 2'd1;
        dec.reg_write = ~is_jr;
        dec.jump      = is_jr ? 2'd2 : 2'd0;
      end
      is_alui: begin
        dec.alu_op    = 2'd3;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_lw: begin
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = 2'd1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      is_sw: begin
        dec.mem_write = 1'b1;
        dec.alu_op    = 2'd1;
        dec.alu_src   = 1'b1;
      end
      is_beq:  dec.branch_beq  = 1'b1;
      is_bne:  dec.branch_bne  = 1'b1;
      is_bgtz: dec.branch_bgtz = 1'b1;
      is_j:    dec.jump        = 2'd1;
      is_jal: begin
        dec.jump      = 2'd1;
        dec.reg_dst   = 2'd2;
        dec.reg_write = 1'b1;
      end
      // with interrupts disabled rti is a plain NOP
      is_rti:  dec.rti     = INTR_EN;
      default: dec.illegal = 1'b1;
    endcase
  end

  logic [1:0] state_q, state_d;
  logic [1:0] base_q, base_d;
  logic [2:0] fcnt_q, fcnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       ack_q, ack_d;
  logic       act_q, act_d;
  logic       redirect;
  logic [1:0] cur_base;

  assign redirect = em_pcsrc | (em_jump != 2'd0);
  assign cur_base = (state_q == S_FLUSH) ? base_q : state_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    fcnt_d  = fcnt_q;
    ctrl_d  = '0;
    ack_d   = 1'b0;
    if (redirect) begin
      fcnt_d  = FLOAD;
      base_d  = cur_base;
      state_d = (FLOAD != 3'd0) ? S_FLUSH : cur_base;
    end else if (state_q == S_FLUSH) begin
      if (fcnt_q != 3'd0) begin
        fcnt_d = fcnt_q - 3'd1;
      end
      if (fcnt_q <= 3'd1) begin
        state_d = base_q;
      end
    end else if (stall) begin
      if (STALL_HOLD) begin
        ctrl_d = ctrl_q;
      end
    end else if (INTR_EN && (state_q == S_RUN) && intr_req) begin
      ack_d   = 1'b1;
      state_d = S_ISR;
    end else begin
      ctrl_d = dec;
      if (dec.rti && (state_q == S_ISR)) begin
        state_d = S_RUN;
      end
    end
    act_d = (state_d == S_ISR) ||
            ((state_d == S_FLUSH) && (base_d == S_ISR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      base_q  <= S_RUN;
      fcnt_q  <= 3'd0;
      ctrl_q  <= '0;
      ack_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      fcnt_q  <= fcnt_d;
      ctrl_q  <= ctrl_d;
      ack_q   <= ack_d;
      act_q   <= act_d;
    end
  end

  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign mem_write   = ctrl_q.mem_write;
  assign mem_read    = ctrl_q.mem_read;
  assign alu_src     = ctrl_q.alu_src;
  assign reg_write   = ctrl_q.reg_write;
  assign branch_bne  = ctrl_q.branch_bne;
  assign branch_bgtz = ctrl_q.branch_bgtz;
  assign branch_beq  = ctrl_q.branch_beq;
  assign alu_op      = ctrl_q.alu_op;
  assign reg_dst     = ctrl_q.reg_dst;
  assign jump        = ctrl_q.jump;
  assign rti_o       = ctrl_q.rti;
  assign illegal_o   = ctrl_q.illegal;
  assign intr_ack    = ack_q;
  assign intr_active = act_q;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: two parameterisations of ctrl_unit_pipe
// checked against a behavioural model plus literal expectations.
module tb_ctrl_unit_pipe;

  typedef struct packed {
    logic       mtr;
    logic       mw;
    logic       mr;
    logic       asrc;
    logic       rw;
    logic       bne;
    logic       bgtz;
    logic       beq;
    logic [1:0] aluop;
    logic [1:0] rdst;
    logic [1:0] jump;
    logic       rti;
    logic       ill;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      o;
    logic       ack;
    logic       isr;
    logic [3:0] left;
  } mst_t;

  localparam logic [31:0] LW   = 32'h8C010004;
  localparam logic [31:0] SW   = 32'hAC010004;
  localparam logic [31:0] ADDI = 32'h20210001;
  localparam logic [31:0] ADD  = 32'h00221820;
  localparam logic [31:0] RTI  = 32'hFC000000;
  localparam logic [31:0] ILL  = 32'hF8000000;
  localparam logic [31:0] BEQ  = 32'h10220003;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        pcsrc;
  logic [1:0]  jmp;
  logic        stl;
  logic        intr;

  logic [1:0]      o_mtr, o_mw, o_mr, o_asrc, o_rw;
  logic [1:0]      o_bne, o_bgtz, o_beq;
  logic [1:0][1:0] o_aluop, o_rdst, o_jump;
  logic [1:0]      o_rti, o_ill, o_ack, o_act;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  mst_t ms [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_unit_pipe #(
      .FLUSH_CYCLES(g == 0 ? 3 : 1),
      .STALL_HOLD  (g == 0 ? 1'b0 : 1'b1),
      .INTR_EN     (1'b1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_instr   (instr),
      .em_pcsrc   (pcsrc),
      .em_jump    (jmp),
      .stall      (stl),
      .intr_req   (intr),
      .mem_to_reg (o_mtr[g]),
      .mem_write  (o_mw[g]),
      .mem_read   (o_mr[g]),
      .alu_src    (o_asrc[g]),
      .reg_write  (o_rw[g]),
      .branch_bne (o_bne[g]),
      .branch_bgtz(o_bgtz[g]),
      .branch_beq (o_beq[g]),
      .alu_op     (o_aluop[g]),
      .reg_dst    (o_rdst[g]),
      .jump       (o_jump[g]),
      .rti_o      (o_rti[g]),
      .illegal_o  (o_ill[g]),
      .intr_ack   (o_ack[g]),
      .intr_active(o_act[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ctrl_t dut_vec(input int g);
    ctrl_t c;
    c.mtr   = o_mtr[g];
    c.mw    = o_mw[g];
    c.mr    = o_mr[g];
    c.asrc  = o_asrc[g];
    c.rw    = o_rw[g];
    c.bne   = o_bne[g];
    c.bgtz  = o_bgtz[g];
    c.beq   = o_beq[g];
    c.aluop = o_aluop[g];
    c.rdst  = o_rdst[g];
    c.jump  = o_jump[g];
    c.rti   = o_rti[g];
    c.ill   = o_ill[g];
    return c;
  endfunction

  // Instruction table straight from the decode rules.
  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    case (ins[31:26])
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c.aluop = 2'd3; c.asrc = 1'b1; c.rw = 1'b1;
      end
      6'h00: begin
        c.aluop = 2'd2; c.rdst = 2'd1;
        if (ins[5:0] == 6'h08) c.jump = 2'd2;
        else c.rw = 1'b1;
      end
      6'h23: begin
        c.mtr = 1'b1; c.mr = 1'b1; c.aluop = 2'd1;
        c.asrc = 1'b1; c.rw = 1'b1;
      end
      6'h2B: begin
        c.mw = 1'b1; c.aluop = 2'd1; c.asrc = 1'b1;
      end
      6'h04: c.beq = 1'b1;
      6'h05: c.bne = 1'b1;
      6'h07: c.bgtz = 1'b1;
      6'h02: c.jump = 2'd1;
      6'h03: begin
        c.jump = 2'd1; c.rdst = 2'd2; c.rw = 1'b1;
      end
      6'h3F: c.rti = 1'b1;
      default: c.ill = 1'b1;
    endcase
    return c;
  endfunction

  // One ID/EX cycle: bubbles owed, ISR flag, held bundle.
  function automatic mst_t mstep(input mst_t s, input int f,
                                 input bit hold,
                                 input logic [31:0] ins,
                                 input logic pc,
                                 input logic [1:0] jm,
                                 input logic st, input logic ir);
    mst_t n;
    n = s;
    n.ack = 1'b0;
    if (pc || jm != 2'd0) begin
      n.o = '0;
      n.left = 4'(f - 1);
    end else if (s.left != 0) begin
      n.o = '0;
      n.left = s.left - 4'd1;
    end else if (st) begin
      if (!hold) n.o = '0;
    end else if (!s.isr && ir) begin
      n.o = '0;
      n.ack = 1'b1;
      n.isr = 1'b1;
    end else begin
      n.o = decode(ins);
      if (n.o.rti && s.isr) n.isr = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms[0] <= '0;
      ms[1] <= '0;
    end else begin
      ms[0] <= mstep(ms[0], 3, 1'b0, instr, pcsrc, jmp, stl, intr);
      ms[1] <= mstep(ms[1], 1, 1'b1, instr, pcsrc, jmp, stl, intr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("model_d%0d", g),
            32'({dut_vec(g), o_ack[g], o_act[g]}),
            32'({ms[g].o, ms[g].ack, ms[g].isr}));
      end
    end
  end

  task automatic cyc(input logic [31:0] ins,
                     input logic pc = 1'b0,
                     input logic [1:0] jm = 2'd0,
                     input logic st = 1'b0,
                     input logic ir = 1'b0,
                     input logic rn = 1'b1);
    #1;
    instr = ins;
    pcsrc = pc;
    jmp   = jm;
    stl   = st;
    intr  = ir;
    rst_n = rn;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  opc;
    r = $urandom;
    case ($urandom_range(0, 11))
      0, 1:    opc = 6'h00;
      2:       opc = 6'(8 + $urandom_range(0, 7));
      3:       opc = 6'h23;
      4:       opc = 6'h2B;
      5:       opc = 6'h04;
      6:       opc = 6'h05;
      7:       opc = 6'h07;
      8:       opc = 6'(2 + $urandom_range(0, 1));
      9, 10:   opc = 6'h3F;
      default: opc = 6'($urandom);
    endcase
    r[31:26] = opc;
    if (opc == 6'h00 && $urandom_range(0, 2) == 0) r[5:0] = 6'h08;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    instr = 32'd0;
    pcsrc = 1'b0;
    jmp   = 2'd0;
    stl   = 1'b0;
    intr  = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_zero", 32'({dut_vec(0), o_ack[0], o_act[0]}), 32'd0);

    cyc(LW);
    chk("lw_mem_read", 32'(o_mr[0]), 32'd1);
    chk("lw_mem_to_reg", 32'(o_mtr[0]), 32'd1);
    chk("lw_alu_op", 32'(o_aluop[0]), 32'd1);
    chk("lw_reg_write", 32'(o_rw[0]), 32'd1);
    chk("model_pin_lw", 32'(ms[0].o.mr), 32'd1);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'(dut_vec(0)), 32'd0);
    @(negedge clk);

    cyc(ADDI, 1'b1);
    chk("flush_b0", 32'(o_aluop[0]), 32'd0);
    cyc(ADDI);
    chk("flush_b1", 32'(o_aluop[0]), 32'd0);
    chk("flush1_d1_resumed", 32'(o_aluop[1]), 32'd3);
    cyc(ADDI);
    chk("flush_b2", 32'(o_aluop[0]), 32'd0);
    cyc(ADDI);
    chk("flush_done", 32'(o_aluop[0]), 32'd3);
    chk("flush_done_src", 32'(o_asrc[0]), 32'd1);

    cyc(ADDI, 1'b1);
    chk("reflush_b0", 32'(o_aluop[0]), 32'd0);
    cyc(ADDI, 1'b1);
    chk("reflush_b1", 32'(o_aluop[0]), 32'd0);
    cyc(ADDI);
    chk("reflush_b2", 32'(o_aluop[0]), 32'd0);
    cyc(ADDI);
    chk("reflush_b3", 32'(o_aluop[0]), 32'd0);
    cyc(ADDI);
    chk("reflush_done", 32'(o_aluop[0]), 32'd3);

    for (int i = 0; i < 2; i++) begin
      cyc(SW, 1'b0, 2'd0, 1'b1);
      chk("stall_bubble", 32'(o_aluop[0]), 32'd0);
      chk("stall_hold_op", 32'(o_aluop[1]), 32'd3);
      chk("stall_hold_mw", 32'(o_mw[1]), 32'd0);
    end
    cyc(SW);
    chk("stall_end_d0", 32'(o_mw[0]), 32'd1);
    chk("stall_end_d1", 32'(o_mw[1]), 32'd1);

    cyc(ADD, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("take_bubble", 32'(dut_vec(0)), 32'd0);
    chk("take_ack", 32'(o_ack[0]), 32'd1);
    chk("take_active", 32'(o_act[0]), 32'd1);
    cyc(ADD, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("isr_no_ack", 32'(o_ack[0]), 32'd0);
    chk("isr_decode", 32'(o_aluop[0]), 32'd2);
    chk("isr_active", 32'(o_act[0]), 32'd1);
    cyc(RTI);
    chk("rti_o", 32'(o_rti[0]), 32'd1);
    chk("rti_inactive", 32'(o_act[0]), 32'd0);

    cyc(ADD, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("retake_ack", 32'(o_ack[0]), 32'd1);
    cyc(RTI, 1'b0, 2'd2);
    chk("rti_squash", 32'(o_rti[0]), 32'd0);
    chk("rti_squash_act", 32'(o_act[0]), 32'd1);
    chk("rti_squash_jump", 32'(o_jump[0]), 32'd0);
    cyc(ADD);
    cyc(ADD);
    chk("isr_flush_act", 32'(o_act[0]), 32'd1);
    cyc(RTI);
    chk("rti2_o", 32'(o_rti[0]), 32'd1);
    chk("rti2_inactive", 32'(o_act[0]), 32'd0);

    cyc(ILL);
    chk("illegal", 32'(dut_vec(0)), 32'h0001);
    cyc(BEQ);
    chk("beq", 32'(o_beq[0]), 32'd1);
    chk("beq_bne", 32'(o_bne[0]), 32'd0);
    chk("beq_ill", 32'(o_ill[0]), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      cyc(rand_instr(),
          1'($urandom_range(0, 7) == 0),
          ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2))
                                      : 2'd0,
          1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 299) != 0));
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
